// File: rtl/servo_pose_sequencer.sv
// servo_pose_sequencer: FIFO of servo poses (duty, dwell) driven through a LOAD/MOVE/DWELL sequencer
module servo_pose_sequencer #(
  parameter int DEPTH       = 8,
  parameter int HOME_DUTY   = 80000,
  parameter int DUTY_MIN    = 50000,
  parameter int DUTY_MAX    = 100000,
  parameter int TICK_CYCLES = 50000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [31:0]              cmd_duty,
  input  logic [15:0]              cmd_dwell,
  input  logic                     run,
  input  logic                     abort,
  output logic [31:0]              duty,
  input  logic [31:0]              current_duty,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err_range
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = TICK_CYCLES > 1 ? $clog2(TICK_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE, LOAD, MOVE, DWELL} state_t;
  state_t        state;
  logic [31:0]   q_duty  [DEPTH];
  logic [15:0]   q_dwell [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [15:0]   dwell_cnt;
  logic [PW-1:0] presc;
  logic          push, pop, lo, hi;
  logic [31:0]   clamped;
  assign cmd_ready = reset && !abort && count < CW'(DEPTH);
  assign push      = cmd_valid && cmd_ready;
  assign pop       = state == LOAD;
  assign lo        = cmd_duty < 32'(DUTY_MIN);
  assign hi        = cmd_duty > 32'(DUTY_MAX);
  assign clamped   = lo ? 32'(DUTY_MIN) : hi ? 32'(DUTY_MAX) : cmd_duty;
  assign busy      = state != IDLE;
  // pose storage; contents are don't-care until written
  always_ff @(posedge clk)
    if (push) begin
      q_duty[wr_ptr]  <= clamped;
      q_dwell[wr_ptr] <= cmd_dwell;
    end
  // queue pointers, occupancy and the sticky range error; abort flushes the queue
  always_ff @(posedge clk)
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      err_range <= 1'b0;
    end else begin
      if (push && (lo || hi)) err_range <= 1'b1;
      if (abort) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  // sequencer: load head pose, wait for the servo to arrive, then hold for the dwell time
  always_ff @(posedge clk)
    if (!reset) begin
      state     <= IDLE;
      duty      <= 32'(HOME_DUTY);
      dwell_cnt <= '0;
      presc     <= '0;
      done      <= 1'b0;
    end else if (abort) begin
      state     <= IDLE;
      duty      <= current_duty;
      dwell_cnt <= '0;
      presc     <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (run && count != '0) state <= LOAD;
        LOAD: begin
          duty      <= q_duty[rd_ptr];
          dwell_cnt <= q_dwell[rd_ptr];
          state     <= MOVE;
        end
        MOVE: if (current_duty == duty) begin
          presc <= '0;
          state <= DWELL;
        end
        DWELL: if (dwell_cnt == '0) begin
          state <= run && count != '0 ? LOAD : IDLE;
          done  <= count == '0;
        end else if (presc == PW'(TICK_CYCLES - 1)) begin
          presc     <= '0;
          dwell_cnt <= dwell_cnt - 16'd1;
        end else begin
          presc <= presc + PW'(1);
        end
      endcase
    end
endmodule

// File: tb/tb_servo_pose_sequencer.sv
// tb_servo_pose_sequencer: directed checks of queueing, clamping, sequencing, abort, pause and reset
module tb_servo_pose_sequencer;
  logic        clk = 1'b0;
  logic        reset, cmd_valid, cmd_ready, run, abort, busy, done, err_range;
  logic [31:0] cmd_duty, duty, current_duty, model_cur, man_cur;
  logic [15:0] cmd_dwell;
  logic [3:0]  count;
  logic        slew_en;
  int          n_vec = 0;
  int          n_err = 0;
  servo_pose_sequencer #(.TICK_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_duty(cmd_duty), .cmd_dwell(cmd_dwell), .run(run), .abort(abort),
    .duty(duty), .current_duty(current_duty), .busy(busy), .done(done),
    .count(count), .err_range(err_range)
  );
  always #5 clk = ~clk;
  // servo feedback: slews 350 ticks per clock toward duty, or follows man_cur when slewing is off
  always @(posedge clk)
    if (!slew_en) model_cur <= man_cur;
    else if (model_cur < duty) model_cur <= (duty - model_cur > 350) ? model_cur + 350 : duty;
    else if (model_cur > duty) model_cur <= (model_cur - duty > 350) ? model_cur - 350 : duty;
  assign current_duty = slew_en ? model_cur : man_cur;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic put(input logic [31:0] d, input logic [15:0] w);
    cmd_valid = 1'b1;
    cmd_duty  = d;
    cmd_dwell = w;
    tick();
    cmd_valid = 1'b0;
  endtask
  initial begin
    int   k;
    logic saw;
    reset = 1'b0; cmd_valid = 1'b0; cmd_duty = '0; cmd_dwell = '0; run = 1'b0; abort = 1'b0;
    slew_en = 1'b1; model_cur = 80000; man_cur = 80000;
    repeat (2) tick();
    chk("rst_duty", duty, 80000);
    chk("rst_count", count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err_range, 0);
    chk("rst_ready", cmd_ready, 0);
    reset = 1'b1;
    #1 chk("ready_after_rst", cmd_ready, 1);
    // two poses with run high: latency, arrival, dwell length, done pulse
    run = 1'b1;
    put(90000, 2);
    chk("lat_e0_duty", duty, 80000);
    chk("lat_e0_count", count, 1);
    put(60000, 0);
    chk("lat_e1_count", count, 2);
    tick();
    chk("lat_e2_duty", duty, 90000);
    chk("lat_e2_count", count, 1);
    for (int i = 0; i < 200 && current_duty !== 90000; i++) tick();
    chk("arrive_90000", current_duty, 90000);
    k = 0;
    while (duty === 90000 && k < 50) begin tick(); k++; end
    chk("dwell_len", k, 11);
    chk("second_duty", duty, 60000);
    for (int i = 0; i < 300 && current_duty !== 60000; i++) tick();
    chk("arrive_60000", current_duty, 60000);
    tick();
    chk("dwell0_busy", busy, 1);
    chk("dwell0_nodone", done, 0);
    tick();
    chk("done_pulse", done, 1);
    chk("idle_busy", busy, 0);
    tick();
    chk("done_single", done, 0);
    // fill queue with run low; ninth write refused; pop and write in the same cycle
    run = 1'b0;
    for (int i = 0; i < 8; i++) put(60000, 0);
    chk("full_count", count, 8);
    cmd_valid = 1'b1; cmd_duty = 70000;
    #1 chk("full_ready", cmd_ready, 0);
    tick();
    chk("ninth_dropped", count, 8);
    run = 1'b1;
    tick();
    chk("load_count", count, 8);
    tick();
    chk("popped_count", count, 7);
    cmd_valid = 1'b0;
    tick();
    tick();
    cmd_valid = 1'b1; run = 1'b0;
    tick();
    chk("pop_push_count", count, 7);
    cmd_valid = 1'b0;
    tick();
    tick();
    chk("pause_busy", busy, 0);
    chk("pause_nodone", done, 0);
    chk("pause_count", count, 7);
    cmd_valid = 1'b1; abort = 1'b1;
    #1 chk("abort_ready", cmd_ready, 0);
    tick();
    chk("flush_count", count, 0);
    abort = 1'b0; cmd_valid = 1'b0;
    // clamping: 120000 -> 100000, 10 -> 50000, sticky error
    put(120000, 0);
    chk("err_set", err_range, 1);
    put(10, 0);
    run = 1'b1;
    for (int i = 0; i < 10 && duty === 60000; i++) tick();
    chk("clamp_hi", duty, 100000);
    for (int i = 0; i < 300 && duty === 100000; i++) tick();
    chk("clamp_lo", duty, 50000);
    for (int i = 0; i < 300 && busy !== 1'b0; i++) tick();
    chk("clamp_idle", busy, 0);
    run = 1'b0;
    chk("err_sticky", err_range, 1);
    // abort in MOVE with three poses queued
    man_cur = 50000; slew_en = 1'b0;
    put(90000, 5); put(70000, 5); put(60000, 5); put(65000, 5);
    run = 1'b1;
    repeat (3) tick();
    chk("move_count", count, 3);
    chk("move_duty", duty, 90000);
    chk("move_busy", busy, 1);
    man_cur = 85000; abort = 1'b1; run = 1'b0;
    tick();
    abort = 1'b0;
    chk("abort_duty", duty, 85000);
    chk("abort_count", count, 0);
    chk("abort_busy", busy, 0);
    chk("abort_nodone", done, 0);
    tick();
    chk("abort_nodone2", done, 0);
    // run dropped during dwell with two poses left, then resumed
    slew_en = 1'b1;
    put(85000, 3); put(86000, 0); put(87000, 0);
    run = 1'b1;
    repeat (3) tick();
    run = 1'b0;
    chk("dwell_count", count, 2);
    chk("dwell_busy", busy, 1);
    for (int i = 0; i < 40 && busy !== 1'b0; i++) tick();
    chk("paused_idle", busy, 0);
    chk("paused_nodone", done, 0);
    chk("paused_count", count, 2);
    run = 1'b1;
    tick();
    chk("resume_busy", busy, 1);
    tick();
    chk("resume_duty", duty, 86000);
    chk("resume_count", count, 1);
    saw = 1'b0;
    for (int i = 0; i < 100 && busy !== 1'b0; i++) begin tick(); saw = saw | done; end
    chk("resume_done", saw, 1);
    chk("resume_empty", count, 0);
    // reset asserted during dwell
    run = 1'b0;
    put(87000, 5); put(70000, 0);
    run = 1'b1;
    repeat (3) tick();
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_err", err_range, 1);
    reset = 1'b0;
    #1 chk("rst_ready_low", cmd_ready, 0);
    tick();
    chk("mid_rst_duty", duty, 80000);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_err", err_range, 0);
    reset = 1'b1; run = 1'b0;
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
